// File: rtl/result_unloader.sv
// Result unloader: captures a 32-bit core result and streams its low NUM_BYTES
// bytes, LSB first, over an 8-bit bus using a four-phase valid/ack handshake.
module result_unloader #(
    parameter int unsigned NUM_BYTES   = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] result,
    input  logic        result_valid,
    output logic [7:0]  out_pins,
    output logic        out_valid,
    output logic        out_last,
    input  logic        host_ack,
    output logic        unloader_busy,
    output logic        overrun,
    input  logic        overrun_clr
);

    localparam int unsigned IDX_W    = 2;
    localparam int unsigned DATA_W   = 32;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESENT,
        S_WAIT_ACK,
        S_WAIT_REL
    } state_e;

    state_e                 state_q, state_d;
    logic [DATA_W-1:0]      shift_q, shift_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [7:0]             pins_q, pins_d;
    logic                   valid_q, valid_d;
    logic                   last_q, last_d;
    logic                   busy_q, busy_d;
    logic                   overrun_q, overrun_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ack_s;

    // host_ack crosses into the clk domain through a plain flop chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], host_ack};
        end
    end

    assign ack_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            idx_q     <= '0;
            pins_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            idx_q     <= idx_d;
            pins_q    <= pins_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        idx_d     = idx_q;
        pins_d    = pins_q;
        valid_d   = valid_q;
        last_d    = last_q;
        busy_d    = busy_q;
        // a new event outranks a simultaneous clear; the dropped result is never latched
        overrun_d = (overrun_q & ~overrun_clr) | (result_valid & (state_q != S_IDLE));

        case (state_q)
            S_IDLE: begin
                if (result_valid) begin
                    shift_d = result;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_PRESENT;
                end
            end
            S_PRESENT: begin
                pins_d  = shift_q[7:0];
                last_d  = (idx_q == LAST_IDX);
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                // valid is raised on the first cycle here, so an early ack is taken one cycle later
                if (valid_q && ack_s) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    state_d = S_WAIT_REL;
                end else begin
                    valid_d = 1'b1;
                end
            end
            S_WAIT_REL: begin
                if (!ack_s) begin
                    if (idx_q == LAST_IDX) begin
                        busy_d  = 1'b0;
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        shift_d = shift_q >> 8;
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_PRESENT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign out_pins      = pins_q;
    assign out_valid     = valid_q;
    assign out_last      = last_q;
    assign unloader_busy = busy_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_result_unloader.sv
// Bench for result_unloader: a 4-byte instance (A) and a 2-byte instance (B)
// driven by a behavioural host; streamed bytes are compared to the result's bytes.
module tb_result_unloader;

    localparam int unsigned SYNC = 2;

    logic        clk;
    logic        rst_n;
    logic [31:0] result;
    logic        rv, ack, clr;
    int          sel;

    logic        rv_a, rv_b, ack_a, ack_b, clr_a, clr_b;
    logic [7:0]  pins_a, pins_b, pins;
    logic        valid_a, valid_b, valid;
    logic        last_a, last_b, last;
    logic        busy_a, busy_b, busy;
    logic        ovr_a, ovr_b, ovr;

    int checks = 0;
    int errors = 0;

    logic [7:0] got_q[$];
    logic       last_q[$];
    int         rise_cnt;
    logic       valid_prev;
    logic       watch11, saw11;

    result_unloader #(.NUM_BYTES(4), .SYNC_STAGES(SYNC)) dut_a (
        .clk(clk), .rst_n(rst_n), .result(result), .result_valid(rv_a),
        .out_pins(pins_a), .out_valid(valid_a), .out_last(last_a),
        .host_ack(ack_a), .unloader_busy(busy_a), .overrun(ovr_a), .overrun_clr(clr_a)
    );

    result_unloader #(.NUM_BYTES(2), .SYNC_STAGES(SYNC)) dut_b (
        .clk(clk), .rst_n(rst_n), .result(result), .result_valid(rv_b),
        .out_pins(pins_b), .out_valid(valid_b), .out_last(last_b),
        .host_ack(ack_b), .unloader_busy(busy_b), .overrun(ovr_b), .overrun_clr(clr_b)
    );

    assign rv_a  = (sel == 0) ? rv  : 1'b0;
    assign rv_b  = (sel == 1) ? rv  : 1'b0;
    assign ack_a = (sel == 0) ? ack : 1'b0;
    assign ack_b = (sel == 1) ? ack : 1'b0;
    assign clr_a = (sel == 0) ? clr : 1'b0;
    assign clr_b = (sel == 1) ? clr : 1'b0;
    assign pins  = (sel == 1) ? pins_b  : pins_a;
    assign valid = (sel == 1) ? valid_b : valid_a;
    assign last  = (sel == 1) ? last_b  : last_a;
    assign busy  = (sel == 1) ? busy_b  : busy_a;
    assign ovr   = (sel == 1) ? ovr_b   : ovr_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid === 1'b1 && valid_prev !== 1'b1) rise_cnt++;
        valid_prev = valid;
        if (watch11 && pins === 8'h11) saw11 = 1'b1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

    // Reference model: byte i of the stream is bits [8i+7:8i] of the result.
    function automatic logic [7:0] exp_byte(input logic [31:0] r, input int i);
        logic [31:0] s;
        s = r >> (8 * i);
        return s[7:0];
    endfunction

    task automatic pulse(input logic [31:0] r);
        result = r;
        rv     = 1'b1;
        @(negedge clk);
        rv     = 1'b0;
    endtask

    // Behavioural host: waits for each byte, acks after ack_dly, releases after hold.
    task automatic run_host(input int nb, input int ack_dly, input int hold, output bit ok);
        int t;
        ok = 1'b1;
        for (int i = 0; i < nb; i++) begin
            t = 0;
            while (valid !== 1'b1 && t < 100) begin @(negedge clk); t++; end
            if (valid !== 1'b1) begin ok = 1'b0; return; end
            got_q.push_back(pins);
            last_q.push_back(last);
            repeat (ack_dly) @(negedge clk);
            ack = 1'b1;
            t = 0;
            while (valid !== 1'b0 && t < 100) begin @(negedge clk); t++; end
            if (valid !== 1'b0) begin ok = 1'b0; ack = 1'b0; return; end
            repeat (hold) @(negedge clk);
            ack = 1'b0;
        end
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        do begin @(negedge clk); cycles++; end while (busy === 1'b1 && cycles < 100);
    endtask

    task automatic clear_log();
        got_q.delete();
        last_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if ({pins_a, valid_a, last_a, busy_a, ovr_a} !== 12'h000 ||
            {pins_b, valid_b, last_b, busy_b, ovr_b} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: A=%h B=%h, expected 000/000",
                     {pins_a, valid_a, last_a, busy_a, ovr_a}, {pins_b, valid_b, last_b, busy_b, ovr_b});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [31:0] r = 32'h8123_45F6;
        bit ok;
        int cyc;
        sel = 0;
        clear_log();
        rise_cnt = 0;
        pulse(r);
        checks++;
        if (busy !== 1'b1 || valid !== 1'b0) begin
            errors++; $display("FAIL single_capture: busy=%b valid=%b, expected 1/0", busy, valid);
        end
        @(negedge clk);
        checks++;
        if (valid !== 1'b0 || pins !== 8'hF6) begin
            errors++; $display("FAIL single_setup: valid=%b pins=%h, expected 0/f6", valid, pins);
        end
        @(negedge clk);
        checks++;
        if (valid !== 1'b1) begin
            errors++; $display("FAIL single_latency: valid=%b two cycles after capture, expected 1", valid);
        end
        run_host(4, 3, 3, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_host: handshake timed out, expected 4 bytes"); end
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL single_busy_hold: busy=%b at final release, expected 1", busy);
        end
        wait_idle(cyc);
        checks++;
        if (cyc != SYNC + 1) begin
            errors++; $display("FAIL single_busy_fall: busy fell %0d cycles after release, expected %0d", cyc, SYNC + 1);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_q.size() <= i || got_q[i] !== exp_byte(r, i) || last_q[i] !== (i == 3)) begin
                errors++;
                $display("FAIL single_byte%0d: got %h last %b, expected %h last %b",
                         i, (got_q.size() > i) ? got_q[i] : 8'hxx, (last_q.size() > i) ? last_q[i] : 1'bx,
                         exp_byte(r, i), (i == 3));
            end
        end
        checks++;
        if (rise_cnt != 4) begin
            errors++; $display("FAIL single_rises: %0d out_valid rises, expected 4", rise_cnt);
        end
    endtask

    task automatic test_negative();
        logic [31:0] r = 32'hFFFF_FFFE;
        bit ok;
        int cyc;
        sel = 1;
        @(negedge clk);
        clear_log();
        pulse(r);
        run_host(2, 2, 2, ok);
        wait_idle(cyc);
        checks++;
        if (!ok || busy !== 1'b0) begin
            errors++; $display("FAIL negative_done: ok=%b busy=%b, expected 1/0", ok, busy);
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (got_q.size() <= i || got_q[i] !== exp_byte(r, i) || last_q[i] !== (i == 1)) begin
                errors++;
                $display("FAIL negative_byte%0d: got %h last %b, expected %h last %b",
                         i, (got_q.size() > i) ? got_q[i] : 8'hxx, (last_q.size() > i) ? last_q[i] : 1'bx,
                         exp_byte(r, i), (i == 1));
            end
        end
        sel = 0;
        @(negedge clk);
    endtask

    task automatic test_overrun();
        logic [31:0] r = 32'h8123_45F6;
        bit ok1, ok2;
        int cyc;
        sel = 0;
        clear_log();
        saw11 = 1'b0;
        watch11 = 1'b1;
        pulse(r);
        run_host(1, 2, 2, ok1);
        cyc = 0;
        while (valid !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
        pulse(32'h1111_1111);
        checks++;
        if (ovr !== 1'b1) begin errors++; $display("FAIL overrun_set: overrun=%b, expected 1", ovr); end
        run_host(3, 2, 2, ok2);
        wait_idle(cyc);
        watch11 = 1'b0;
        checks++;
        if (!ok1 || !ok2 || saw11) begin
            errors++; $display("FAIL overrun_stream: ok=%b%b saw11=%b, expected 11/0", ok1, ok2, saw11);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_q.size() <= i || got_q[i] !== exp_byte(r, i)) begin
                errors++;
                $display("FAIL overrun_byte%0d: got %h, expected %h",
                         i, (got_q.size() > i) ? got_q[i] : 8'hxx, exp_byte(r, i));
            end
        end
        checks++;
        if (ovr !== 1'b1 || valid !== 1'b0) begin
            errors++; $display("FAIL overrun_sticky: overrun=%b valid=%b, expected 1/0", ovr, valid);
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if (ovr !== 1'b0) begin errors++; $display("FAIL overrun_clear: overrun=%b, expected 0", ovr); end
    endtask

    task automatic test_collision();
        logic [31:0] r = $urandom;
        bit ok1, ok2;
        int cyc;
        sel = 0;
        clear_log();
        pulse(r);
        run_host(1, 1, 1, ok1);
        pulse($urandom);
        clr = 1'b1;
        rv  = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        rv  = 1'b0;
        checks++;
        if (ovr !== 1'b1) begin
            errors++; $display("FAIL collision_set_wins: overrun=%b, expected 1", ovr);
        end
        run_host(3, 1, 1, ok2);
        wait_idle(cyc);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (!ok1 || !ok2 || got_q.size() <= i || got_q[i] !== exp_byte(r, i)) begin
                errors++;
                $display("FAIL collision_byte%0d: got %h, expected %h",
                         i, (got_q.size() > i) ? got_q[i] : 8'hxx, exp_byte(r, i));
            end
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_slow_host();
        logic [31:0] r = $urandom;
        bit ok;
        bit held;
        int cyc;
        sel = 0;
        clear_log();
        pulse(r);
        cyc = 0;
        while (valid !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
        got_q.push_back(pins);
        last_q.push_back(last);
        ack = 1'b1;
        cyc = 0;
        while (valid !== 1'b0 && cyc < 100) begin @(negedge clk); cyc++; end
        held = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (valid !== 1'b0 || pins !== exp_byte(r, 0)) held = 1'b0;
        end
        checks++;
        if (!held) begin
            errors++; $display("FAIL slow_hold: valid=%b pins=%h during ack hold, expected 0/%h", valid, pins, exp_byte(r, 0));
        end
        ack = 1'b0;
        // SYNC edges to propagate, one edge for the FSM to see it, then two to valid
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (valid !== 1'b1 && cyc < 100);
        checks++;
        if (cyc != SYNC + 3) begin
            errors++; $display("FAIL slow_release_latency: valid after %0d cycles, expected %0d", cyc, SYNC + 3);
        end
        run_host(3, 2, 1, ok);
        wait_idle(cyc);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (!ok || got_q.size() <= i || got_q[i] !== exp_byte(r, i)) begin
                errors++;
                $display("FAIL slow_byte%0d: got %h, expected %h",
                         i, (got_q.size() > i) ? got_q[i] : 8'hxx, exp_byte(r, i));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r  = $urandom;
        logic [31:0] r2 = $urandom;
        bit ok;
        int cyc;
        sel = 0;
        clear_log();
        pulse(r);
        run_host(1, 1, 1, ok);
        cyc = 0;
        while (valid !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0 || pins !== 8'h00 || last !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_async: valid=%b busy=%b pins=%h last=%b, expected 0/0/00/0", valid, busy, pins, last);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_log();
        pulse(r2);
        run_host(4, 1, 1, ok);
        wait_idle(cyc);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (!ok || got_q.size() <= i || got_q[i] !== exp_byte(r2, i)) begin
                errors++;
                $display("FAIL reset_mid_byte%0d: got %h, expected %h",
                         i, (got_q.size() > i) ? got_q[i] : 8'hxx, exp_byte(r2, i));
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] r;
        bit ok;
        int cyc;
        int nb;
        for (int n = 0; n < 8; n++) begin
            sel = int'($urandom_range(0, 1));
            nb  = (sel == 1) ? 2 : 4;
            r   = $urandom;
            @(negedge clk);
            clear_log();
            pulse(r);
            run_host(nb, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), ok);
            wait_idle(cyc);
            checks++;
            if (!ok || busy !== 1'b0 || ovr !== 1'b0) begin
                errors++; $display("FAIL random%0d_done: ok=%b busy=%b overrun=%b, expected 1/0/0", n, ok, busy, ovr);
            end
            for (int i = 0; i < nb; i++) begin
                checks++;
                if (got_q.size() <= i || got_q[i] !== exp_byte(r, i) || last_q[i] !== (i == nb - 1)) begin
                    errors++;
                    $display("FAIL random%0d_byte%0d: got %h last %b, expected %h last %b",
                             n, i, (got_q.size() > i) ? got_q[i] : 8'hxx, (last_q.size() > i) ? last_q[i] : 1'bx,
                             exp_byte(r, i), (i == nb - 1));
                end
            end
        end
        sel = 0;
    endtask

    initial begin
        rst_n      = 1'b0;
        result     = '0;
        rv         = 1'b0;
        ack        = 1'b0;
        clr        = 1'b0;
        sel        = 0;
        rise_cnt   = 0;
        valid_prev = 1'b0;
        watch11    = 1'b0;
        saw11      = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_negative();
        test_overrun();
        test_collision();
        test_slow_host();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/result_unloader.md
Name: result_unloader

Overview:
- Output-side counterpart to the parameter loading path.
- Captures the signed 32-bit result produced by the calculation core and serializes it byte by byte onto an 8-bit output pin bus.
- Uses a four-phase valid/ack handshake with the external host.
- Exposes a busy flag so the loader/core pair can hold off issuing a new calculation while a result is still being drained.

Parameters:
- NUM_BYTES, 4, number of bytes sent per result (1..4); the low NUM_BYTES bytes of the result are sent.
- SYNC_STAGES, 2, flip-flop stages on the asynchronous host_ack pin (minimum 2).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- result  input  32  signed core result, sampled only when result_valid=1
- result_valid  input  1  single-cycle strobe from core: result is ready
- out_pins  output  8  current byte presented to host
- out_valid  output  1  byte on out_pins is stable and valid
- out_last  output  1  high together with out_valid on the final byte of a result
- host_ack  input  1  host acknowledge, asynchronous to clk
- unloader_busy  output  1  high from capture until the final handshake completes
- overrun  output  1  sticky: result_valid arrived while busy
- overrun_clr  input  1  synchronous clear of overrun

Behaviour:
- Reset values:
  - out_pins=0, out_valid=0, out_last=0, unloader_busy=0, overrun=0.
  - Byte index=0, state=S_IDLE, host_ack synchronizer chain all 0.
- host_ack passes through SYNC_STAGES flops; ack_s denotes the synchronized value. Only ack_s is used.
- States: S_IDLE, S_PRESENT, S_WAIT_ACK, S_WAIT_REL.
- S_IDLE:
  - If result_valid=1, latch result into a 32-bit shift register, set byte index=0, set unloader_busy=1, go to S_PRESENT.
  - Capture cycle is the edge where result_valid=1 is sampled.
- S_PRESENT:
  - out_pins <= shift_reg[7:0].
  - out_last <= (index==NUM_BYTES-1).
  - Go to S_WAIT_ACK.
  - out_valid rises one cycle after out_pins is updated, so data is set up one full clock before valid. Concretely, out_valid is set on entry to S_WAIT_ACK.
- S_WAIT_ACK:
  - Hold out_pins/out_valid/out_last.
  - When ack_s=1: out_valid <= 0, out_last <= 0, go to S_WAIT_REL.
- S_WAIT_REL:
  - Wait for ack_s=0.
  - If index==NUM_BYTES-1: unloader_busy <= 0, index <= 0, go to S_IDLE.
  - Otherwise: shift register >>8, index+1, go to S_PRESENT.
- out_pins holds its last value after a transfer; it is not cleared.
- Latencies:
  - Capture to first out_valid: 2 cycles.
  - ack_s fall to next out_valid: 2 cycles.
- Byte order: LSB first. Raw two's-complement bytes, no sign processing. Upper bytes beyond NUM_BYTES are discarded.
- Overrun:
  - result_valid=1 in any state other than S_IDLE sets overrun=1.
  - The new result is dropped; the transfer in progress is unaffected.
- overrun_clr:
  - overrun_clr=1 clears overrun.
  - If overrun_clr=1 and a new overrun event occur in the same cycle, set wins (overrun=1).
- result_valid in S_IDLE in the same cycle as the final S_WAIT_REL exit cannot occur; S_IDLE is a separate cycle. result_valid on that exit cycle counts as overrun.
- ack_s already high when entering S_WAIT_ACK: the byte is accepted immediately on the next cycle. This is legal but not a protocol-compliant host.
- Reset mid-transfer: all outputs return to reset values immediately (asynchronously) and the partial result is lost.

Test Plan:
- Single transfer:
  - Stimulus: result=32'h8123_45F6, result_valid pulse, host acks each byte after 3 cycles.
  - Required: bytes F6,45,23,81 in order; out_last only on 81; unloader_busy falls after the final ack release; exactly 4 out_valid rising edges.
- Negative value:
  - Stimulus: result=-2 (32'hFFFF_FFFE), NUM_BYTES=2.
  - Required: bytes FE,FF; out_last on the second byte; busy low after 2 handshakes.
- Overrun:
  - Stimulus: second result_valid (result=32'h1111_1111) during the byte-1 wait.
  - Required: overrun=1; the stream still equals the first result; 32'h11 never appears on out_pins. Then overrun_clr=1 -> overrun=0 next cycle.
- Clear/set collision:
  - Stimulus: overrun_clr and an overrun-causing result_valid in the same cycle.
  - Required: overrun stays 1.
- Slow host:
  - Stimulus: host holds ack high for 20 cycles.
  - Required: out_valid stays 0 and no new byte is presented until ack_s is low; the next out_valid follows exactly 2 cycles after ack_s falls.
- Reset mid-transfer:
  - Stimulus: assert rst_n=0 while the second byte is valid.
  - Required: out_valid, unloader_busy and out_pins are 0 without waiting for a clk edge. A new result after release transfers from byte 0.
